// File: rtl/dfe_tap_train_ctrl.sv
// dfe_tap_train_ctrl
// Training / adaptation controller for the receive-side DFE post-cursor tap.
// Sequences IDLE -> TRAIN -> RUN | FAIL. In TRAIN the single feedback tap is
// adapted with sign-sign LMS against known PAM4 reference symbols.
//
// Optional feature macro: DFE_DD_ADAPT_EN
//   defined   : RUN keeps adapting the tap decision-directed (decision_in is
//               the reference, previous decision is prev_ref).
//   undefined : tap is frozen in RUN and FAIL.
//
// Handshake: a training symbol is consumed only on a cycle where eq_in_valid
// and train_data_valid are both high; there is no backpressure, every such
// cycle is accepted, and a lone valid is ignored without side effects.
//
// dbg_state exposes the registered FSM state: 0=IDLE, 1=TRAIN, 2=RUN, 3=FAIL.
module dfe_tap_train_ctrl #(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int TAP_WIDTH         = 12,
  parameter int TAP_INIT          = 0,
  parameter int TAP_STEP          = 1,
  parameter int ERR_THRESH        = 8,
  parameter int CONV_COUNT        = 16,
  parameter int TRAIN_LENGTH      = 256
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic signed [SIGNAL_RESOLUTION-1:0] eq_in,
  input  logic                                eq_in_valid,
  input  logic signed [SIGNAL_RESOLUTION-1:0] decision_in,
  input  logic signed [SIGNAL_RESOLUTION-1:0] train_data,
  input  logic                                train_data_valid,
  output logic signed [TAP_WIDTH-1:0]         tap_out,
  output logic                                mode_train,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic signed [SIGNAL_RESOLUTION:0]   err_out,
  output logic [1:0]                          dbg_state
);

  // Error is one bit wider than the operands so the difference never wraps.
  localparam int EW = SIGNAL_RESOLUTION + 1;
  localparam int GW = $clog2(CONV_COUNT + 1);
  localparam int SW = $clog2(TRAIN_LENGTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRAIN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  // Tap arithmetic is done one bit wider and then clamped.
  localparam logic signed [TAP_WIDTH:0] STEP_W = (TAP_WIDTH+1)'(TAP_STEP);
  localparam logic signed [TAP_WIDTH:0] MAX_W  = (TAP_WIDTH+1)'((2 ** (TAP_WIDTH-1)) - 1);
  localparam logic signed [TAP_WIDTH:0] MIN_W  = ~MAX_W;
  localparam logic signed [TAP_WIDTH-1:0] TAP_INIT_V = TAP_WIDTH'(TAP_INIT);
  localparam logic signed [EW-1:0] THRESH_W = EW'(ERR_THRESH);
  localparam logic [GW-1:0] CONV_V = GW'(CONV_COUNT);
  localparam logic [SW-1:0] LEN_V  = SW'(TRAIN_LENGTH);

  logic [1:0]                          state_q, state_d;
  logic signed [TAP_WIDTH-1:0]         tap_q, tap_d;
  logic signed [EW-1:0]                err_q, err_d;
  logic signed [SIGNAL_RESOLUTION-1:0] prev_ref_q, prev_ref_d;
  logic [GW-1:0]                       good_q, good_d;
  logic [SW-1:0]                       sym_q, sym_d;
  logic                                train_q, done_q, conv_q;

  logic                                qual;
  logic                                err_good;
  logic signed [EW-1:0]                err_train;
  logic signed [EW-1:0]                err_dec;

  // One sign-sign LMS step with saturation; no move when either sign is zero.
  function automatic logic signed [TAP_WIDTH-1:0] ss_update(
    input logic signed [TAP_WIDTH-1:0]         tap,
    input logic signed [EW-1:0]                err,
    input logic signed [SIGNAL_RESOLUTION-1:0] ref_sym
  );
    logic signed [TAP_WIDTH:0] wide;
    wide = {tap[TAP_WIDTH-1], tap};
    if (err != '0 && ref_sym != '0) begin
      if (err[EW-1] == ref_sym[SIGNAL_RESOLUTION-1]) begin
        wide = wide + STEP_W;
      end else begin
        wide = wide - STEP_W;
      end
    end
    if (wide > MAX_W) begin
      wide = MAX_W;
    end else if (wide < MIN_W) begin
      wide = MIN_W;
    end
    return wide[TAP_WIDTH-1:0];
  endfunction

  assign qual      = eq_in_valid && train_data_valid;
  assign err_train = $signed({eq_in[SIGNAL_RESOLUTION-1], eq_in})
                   - $signed({train_data[SIGNAL_RESOLUTION-1], train_data});
  assign err_dec   = $signed({eq_in[SIGNAL_RESOLUTION-1], eq_in})
                   - $signed({decision_in[SIGNAL_RESOLUTION-1], decision_in});
  assign err_good  = (err_train <= THRESH_W) && (err_train >= -THRESH_W);

  // Next-state, tap adaptation and counter logic.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    err_d      = err_q;
    prev_ref_d = prev_ref_q;
    good_d     = good_q;
    sym_d      = sym_q;
    case (state_q)
      ST_TRAIN: begin
        // start is deliberately ignored while training.
        if (qual) begin
          tap_d      = ss_update(tap_q, err_train, prev_ref_q);
          err_d      = err_train;
          prev_ref_d = train_data;
          sym_d      = sym_q + SW'(1);
          good_d     = err_good ? (good_q + GW'(1)) : '0;
          // Convergence takes priority over budget exhaustion on the same symbol.
          if (good_d == CONV_V) begin
            state_d    = ST_RUN;
            prev_ref_d = '0;
          end else if (sym_d == LEN_V) begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_RUN: begin
        if (start) begin
          state_d    = ST_TRAIN;
          tap_d      = TAP_INIT_V;
          err_d      = '0;
          prev_ref_d = '0;
          good_d     = '0;
          sym_d      = '0;
        end else if (eq_in_valid) begin
          err_d = err_dec;
`ifdef DFE_DD_ADAPT_EN
          tap_d      = ss_update(tap_q, err_dec, prev_ref_q);
          prev_ref_d = decision_in;
`else
          tap_d      = tap_q;
`endif
        end
      end
      default: begin
        // IDLE and FAIL: hold everything until a new training request.
        if (start) begin
          state_d    = ST_TRAIN;
          tap_d      = TAP_INIT_V;
          err_d      = '0;
          prev_ref_d = '0;
          good_d     = '0;
          sym_d      = '0;
        end
      end
    endcase
  end

  // State, tap, error and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tap_q      <= TAP_INIT_V;
      err_q      <= '0;
      prev_ref_q <= '0;
      good_q     <= '0;
      sym_q      <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      err_q      <= err_d;
      prev_ref_q <= prev_ref_d;
      good_q     <= good_d;
      sym_q      <= sym_d;
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      train_q <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      train_q <= (state_d == ST_TRAIN);
      done_q  <= (state_d == ST_RUN) || (state_d == ST_FAIL);
      conv_q  <= (state_d == ST_RUN);
    end
  end

  assign tap_out    = tap_q;
  assign err_out    = err_q;
  assign mode_train = train_q;
  assign busy       = train_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dfe_tap_train_ctrl.sv
// Bench for dfe_tap_train_ctrl. Inputs are driven on the falling edge; the
// reference model predicts the registered outputs after the next rising edge
// and queues them; the monitor compares one entry per cycle after that edge.
module tb_dfe_tap_train_ctrl;

  localparam int SR    = 8;
  localparam int TW    = 5;
  localparam int TINIT = 0;
  localparam int STEP  = 1;
  localparam int TH    = 8;
  localparam int CONV  = 16;
  localparam int LEN   = 32;
  localparam int W     = 2 + TW + (SR + 1) + 4;

  localparam int S_IDLE  = 0;
  localparam int S_TRAIN = 1;
  localparam int S_RUN   = 2;
  localparam int S_FAIL  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic signed [SR-1:0] eq_in = '0;
  logic                 eq_in_valid = 1'b0;
  logic signed [SR-1:0] decision_in = '0;
  logic signed [SR-1:0] train_data = '0;
  logic                 train_data_valid = 1'b0;
  logic signed [TW-1:0] tap_out;
  logic                 mode_train, busy, done, converged;
  logic signed [SR:0]   err_out;
  logic [1:0]           dbg_state;

  dfe_tap_train_ctrl #(
    .SIGNAL_RESOLUTION(SR), .TAP_WIDTH(TW), .TAP_INIT(TINIT), .TAP_STEP(STEP),
    .ERR_THRESH(TH), .CONV_COUNT(CONV), .TRAIN_LENGTH(LEN)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .eq_in(eq_in), .eq_in_valid(eq_in_valid), .decision_in(decision_in),
    .train_data(train_data), .train_data_valid(train_data_valid),
    .tap_out(tap_out), .mode_train(mode_train), .busy(busy), .done(done),
    .converged(converged), .err_out(err_out), .dbg_state(dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;
  string        cur_tag = "reset";

  // reference model: behavioural view of the controller
  int m_state = S_IDLE;
  int m_tap   = TINIT;
  int m_err   = 0;
  int m_good  = 0;
  int m_sym   = 0;
  int m_pref  = 0;

  function automatic int clamp_tap(input int v);
    int hi, lo;
    hi = (1 << (TW - 1)) - 1;
    lo = -(1 << (TW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  task automatic model_step();
    int e;
    if (rst) begin
      m_state = S_IDLE; m_tap = TINIT; m_err = 0;
      m_good = 0; m_sym = 0; m_pref = 0;
    end else if (m_state != S_TRAIN && start) begin
      m_state = S_TRAIN; m_tap = TINIT; m_err = 0;
      m_good = 0; m_sym = 0; m_pref = 0;
    end else if (m_state == S_TRAIN) begin
      if (eq_in_valid && train_data_valid) begin
        e = int'(eq_in) - int'(train_data);
        if (e != 0 && m_pref != 0)
          m_tap = clamp_tap(m_tap + ((sgn(e) == sgn(m_pref)) ? STEP : -STEP));
        m_err  = e;
        m_pref = int'(train_data);
        m_sym  = m_sym + 1;
        m_good = (e <= TH && e >= -TH) ? m_good + 1 : 0;
        if (m_good == CONV)     m_state = S_RUN;
        else if (m_sym == LEN)  m_state = S_FAIL;
      end
    end else if (m_state == S_RUN && eq_in_valid) begin
      m_err = int'(eq_in) - int'(decision_in);
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic tr, dn, cv;
    tr = (m_state == S_TRAIN);
    dn = (m_state == S_RUN) || (m_state == S_FAIL);
    cv = (m_state == S_RUN);
    return {2'(m_state), TW'(m_tap), (SR+1)'(m_err), tr, tr, dn, cv};
  endfunction

  // driver: one clock of stimulus plus its predicted response
  task automatic drive(input logic r, input logic s, input logic ev,
                       input logic signed [SR-1:0] eq, input logic signed [SR-1:0] dec,
                       input logic tv, input logic signed [SR-1:0] td);
    @(negedge clk);
    rst = r; start = s; eq_in_valid = ev; eq_in = eq;
    decision_in = dec; train_data_valid = tv; train_data = td;
    model_step();
    exp_q.push_back(model_vec());
    tag_q.push_back(cur_tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic signed [SR-1:0] pam4(input logic pos_only);
    int lv;
    lv = ($urandom_range(0, 1) == 0) ? 32 : 96;
    if (!pos_only && $urandom_range(0, 1) == 1) lv = -lv;
    return SR'(lv);
  endfunction

  // qualifying training symbol with a chosen error
  task automatic sym(input logic signed [SR-1:0] td, input int e);
    drive(1'b0, 1'b0, 1'b1, SR'(int'(td) + e), pam4(1'b0), 1'b1, td);
  endtask

  // monitor
  initial begin
    logic [W-1:0] exp_v, act_v;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        t = tag_q.pop_front();
        act_v = {dbg_state, tap_out, err_out, mode_train, busy, done, converged};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL %s t=%0t got st=%0d tap=%0d err=%0d flags=%b exp st=%0d tap=%0d err=%0d flags=%b",
                   t, $time, act_v[W-1 -: 2], $signed(act_v[W-3 -: TW]),
                   $signed(act_v[3 +: SR+1]), act_v[3:0],
                   exp_v[W-1 -: 2], $signed(exp_v[W-3 -: TW]),
                   $signed(exp_v[3 +: SR+1]), exp_v[3:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic signed [SR-1:0] td;
    int e;
    cur_tag = "reset";
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(2);

    cur_tag = "ideal";
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 20; i++) sym(pam4(1'b0), 0);

    cur_tag = "isi";
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 18; i++) sym(pam4(1'b1), 4);

    cur_tag = "train_start";
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 5; i++) sym(pam4(1'b1), 3);
    drive(1'b0, 1'b1, 1'b1, 8'sd40, 8'sd32, 1'b1, 8'sd32);
    for (int i = 0; i < 4; i++) sym(pam4(1'b0), -2);

    cur_tag = "rst_mid";
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, pam4(1'b0), pam4(1'b0), 1'b1, pam4(1'b0));
    idle(2);

    cur_tag = "fail_clamp";
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 32; i++) sym(pam4(1'b1), 20);
    for (int i = 0; i < 4; i++) sym(pam4(1'b0), 20);

    cur_tag = "fail_rand";
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 34; i++) sym(pam4(1'b0), ($urandom_range(0, 1) == 1) ? 20 : -20);

    cur_tag = "skew";
    drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 40; i++) begin
      td = pam4(1'b0);
      e  = int'($urandom_range(0, 16)) - 8;
      drive(1'b0, 1'b0, 1'b1, SR'(int'(td) + e), pam4(1'b0), 1'(i % 2), td);
    end
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), pam4(1'b0), pam4(1'b0), 1'b0, '0);

    cur_tag = "random";
    for (int i = 0; i < 400; i++) begin
      td = pam4(1'b0);
      e  = int'($urandom_range(0, 24)) - 12;
      drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 3) != 0), SR'(int'(td) + e), pam4(1'b0),
            1'($urandom_range(0, 3) != 0), td);
    end
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
